// File: rtl/time_pkg.sv
// Shared field widths, encodings and BCD time-of-day arithmetic for the
// time-of-day controller and its display-side interface.
package time_pkg;

  localparam int SEC_U_W = 4;
  localparam int SEC_D_W = 3;
  localparam int MIN_U_W = 4;
  localparam int MIN_D_W = 3;
  localparam int HRS_U_W = 4;
  localparam int HRS_D_W = 2;

  localparam int MAX_HRS_D        = 2;
  localparam int MAX_HRS_U_AT_2   = 3;
  localparam int MAX_TENS_MIN_SEC = 5;

  typedef enum logic [1:0] {
    EDIT_NONE = 2'd0,
    EDIT_HRS  = 2'd1,
    EDIT_MIN  = 2'd2
  } edit_t;

  typedef enum logic [1:0] {
    RUN,
    SET_HRS,
    SET_MIN
  } state_t;

  typedef struct packed {
    logic [HRS_D_W-1:0] hrs_d;
    logic [HRS_U_W-1:0] hrs_u;
    logic [MIN_D_W-1:0] min_d;
    logic [MIN_U_W-1:0] min_u;
    logic [SEC_D_W-1:0] sec_d;
    logic [SEC_U_W-1:0] sec_u;
  } tod_t;

  function automatic tod_t inc_hours(tod_t t);
    tod_t r;
    r = t;
    if (t.hrs_d == HRS_D_W'(MAX_HRS_D) && t.hrs_u == HRS_U_W'(MAX_HRS_U_AT_2)) begin
      r.hrs_d = '0;
      r.hrs_u = '0;
    end else if (t.hrs_u == HRS_U_W'(9)) begin
      r.hrs_u = '0;
      r.hrs_d = t.hrs_d + HRS_D_W'(1);
    end else begin
      r.hrs_u = t.hrs_u + HRS_U_W'(1);
    end
    return r;
  endfunction

  // Minutes wrap 59->00 on their own; callers decide whether hours carry.
  function automatic tod_t inc_minutes(tod_t t);
    tod_t r;
    r = t;
    if (t.min_u == MIN_U_W'(9)) begin
      r.min_u = '0;
      r.min_d = (t.min_d == MIN_D_W'(MAX_TENS_MIN_SEC)) ? '0 : t.min_d + MIN_D_W'(1);
    end else begin
      r.min_u = t.min_u + MIN_U_W'(1);
    end
    return r;
  endfunction

  function automatic tod_t next_second(tod_t t);
    tod_t r;
    r = t;
    if (t.sec_u != SEC_U_W'(9)) begin
      r.sec_u = t.sec_u + SEC_U_W'(1);
    end else begin
      r.sec_u = '0;
      if (t.sec_d != SEC_D_W'(MAX_TENS_MIN_SEC)) begin
        r.sec_d = t.sec_d + SEC_D_W'(1);
      end else begin
        r.sec_d = '0;
        if (t.min_u == MIN_U_W'(9) && t.min_d == MIN_D_W'(MAX_TENS_MIN_SEC)) begin
          r.min_u = '0;
          r.min_d = '0;
          r = inc_hours(r);
        end else begin
          r = inc_minutes(r);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Display-side bundle of digit fields and edit qualifiers produced by the
// time-of-day controller.
interface time_set_controller_if;
  import time_pkg::*;

  logic [SEC_U_W-1:0] sec_u;
  logic [SEC_D_W-1:0] sec_d;
  logic [MIN_U_W-1:0] min_u;
  logic [MIN_D_W-1:0] min_d;
  logic [HRS_U_W-1:0] hrs_u;
  logic [HRS_D_W-1:0] hrs_d;
  logic [1:0]         edit_field;
  logic               blink;
  logic               tick_1hz;

  modport master (output sec_u, sec_d, min_u, min_d, hrs_u, hrs_d, edit_field, blink, tick_1hz);
  modport slave  (input  sec_u, sec_d, min_u, min_d, hrs_u, hrs_d, edit_field, blink, tick_1hz);
endinterface

// File: rtl/time_set_controller_button_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge press
// pulse for one raw push button.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 315_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pressed_q, pressed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_comb begin
    level_d   = level_q;
    pressed_d = 1'b0;
    cnt_d     = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d   = sync2_q;
        pressed_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      pressed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pressed = pressed_q;

endmodule

// File: rtl/time_set_controller.sv
// HH:MM:SS time-of-day keeper with 1 Hz prescaler and a two-button
// set-hours / set-minutes mode, feeding the VGA clock display datapath.
module time_set_controller
  import time_pkg::*;
#(
  parameter int          CLK_HZ          = 31_500_000,
  parameter int          DEBOUNCE_CYCLES = 315_000,
  parameter logic [7:0]  RST_HRS         = 8'h19,
  parameter logic [7:0]  RST_MIN         = 8'h38
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               btn_mode,
  input  logic               btn_inc,
  output logic [SEC_U_W-1:0] sec_u,
  output logic [SEC_D_W-1:0] sec_d,
  output logic [MIN_U_W-1:0] min_u,
  output logic [MIN_D_W-1:0] min_d,
  output logic [HRS_U_W-1:0] hrs_u,
  output logic [HRS_D_W-1:0] hrs_d,
  output logic [1:0]         edit_field,
  output logic               blink,
  output logic               tick_1hz
);

  localparam int              PS_W    = $clog2(CLK_HZ + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_HZ / 2);
  localparam tod_t RST_TOD = '{hrs_d: RST_HRS[5:4], hrs_u: RST_HRS[3:0],
                               min_d: RST_MIN[6:4], min_u: RST_MIN[3:0],
                               sec_d: '0, sec_u: '0};

  logic [1:0] btn_raw, press;
  assign btn_raw = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .btn_raw (btn_raw[gi]),
      .pressed (press[gi])
    );
  end

  logic mode_p, inc_p;
  assign mode_p = press[0];
  assign inc_p  = press[1];

  state_t          state_q, state_d;
  tod_t            tod_q, tod_d;
  logic [PS_W-1:0] presc_q, presc_d;
  edit_t           edit_q, edit_d;
  logic            blink_q, blink_d;
  logic            tick_q, tick_d;
  logic            wrap;

  always_comb begin
    wrap    = (presc_q == PS_LAST);
    presc_d = wrap ? '0 : presc_q + PS_W'(1);
    state_d = state_q;
    tod_d   = tod_q;
    tick_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (wrap) tod_d = next_second(tod_q);
        // Leaving RUN suppresses the tick so it never shows up in a SET state.
        if (mode_p) state_d = SET_HRS;
        else        tick_d  = wrap;
      end
      SET_HRS: begin
        if (mode_p)     state_d = SET_MIN;
        else if (inc_p) tod_d   = inc_hours(tod_q);
      end
      SET_MIN: begin
        if (mode_p) begin
          state_d     = RUN;
          tod_d.sec_u = '0;
          tod_d.sec_d = '0;
          presc_d     = '0;
        end else if (inc_p) begin
          tod_d = inc_minutes(tod_q);
        end
      end
      default: state_d = RUN;
    endcase
    case (state_d)
      SET_HRS: edit_d = EDIT_HRS;
      SET_MIN: edit_d = EDIT_MIN;
      default: edit_d = EDIT_NONE;
    endcase
    // Built from next-state values so blink lines up with the visible prescaler count.
    blink_d = (state_d != RUN) && (presc_d >= PS_HALF);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RUN;
      tod_q   <= RST_TOD;
      presc_q <= '0;
      edit_q  <= EDIT_NONE;
      blink_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tod_q   <= tod_d;
      presc_q <= presc_d;
      edit_q  <= edit_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
    end
  end

  assign sec_u      = tod_q.sec_u;
  assign sec_d      = tod_q.sec_d;
  assign min_u      = tod_q.min_u;
  assign min_d      = tod_q.min_d;
  assign hrs_u      = tod_q.hrs_u;
  assign hrs_d      = tod_q.hrs_d;
  assign edit_field = edit_q;
  assign blink      = blink_q;
  assign tick_1hz   = tick_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench: tick scoreboard, set-mode vector table and hand-written
// bounce / simultaneous-press / reset corner sequences.
module tb_time_set_controller;
  import time_pkg::*;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
  localparam logic [7:0] CARRY_HRS [3] = '{8'h23, 8'h09, 8'h19};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rst_c_n = 1'b0;
  logic btn_mode = 1'b0;
  logic btn_inc = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  time_set_controller_if dif ();

  time_set_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB),
                        .RST_HRS(8'h19), .RST_MIN(8'h38)) dut (
    .clk(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_u(dif.sec_u), .sec_d(dif.sec_d), .min_u(dif.min_u), .min_d(dif.min_d),
    .hrs_u(dif.hrs_u), .hrs_d(dif.hrs_d), .edit_field(dif.edit_field),
    .blink(dif.blink), .tick_1hz(dif.tick_1hz)
  );

  function automatic int to_hms(logic [3:0] hd, logic [3:0] hu, logic [3:0] md,
                                logic [3:0] mu, logic [3:0] sd, logic [3:0] su);
    return (int'(hd) * 10 + int'(hu)) * 10000 + (int'(md) * 10 + int'(mu)) * 100
           + int'(sd) * 10 + int'(su);
  endfunction

  logic [31:0] carry_hms [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_carry
    logic [3:0] su, mu, hu;
    logic [2:0] sd, md;
    logic [1:0] hd, ef;
    logic       bl, tk;
    time_set_controller #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DEB),
                          .RST_HRS(CARRY_HRS[gi]), .RST_MIN(8'h59)) u_dut (
      .clk(clk), .reset_n(rst_c_n), .btn_mode(1'b0), .btn_inc(1'b0),
      .sec_u(su), .sec_d(sd), .min_u(mu), .min_d(md), .hrs_u(hu), .hrs_d(hd),
      .edit_field(ef), .blink(bl), .tick_1hz(tk)
    );
    assign carry_hms[gi] = to_hms(4'(hd), hu, 4'(md), mu, 4'(sd), su);
  end

  typedef struct {
    int cyc;
    int hms;
  } tick_exp_t;

  typedef struct {
    bit   is_mode;
    int   presses;
    int   edit;
    int   hms;
  } vec_t;

  tick_exp_t sb[$];
  vec_t      vecs[4];
  int        exp599[3] = '{235959, 95959, 195959};
  int        exp600[3] = '{0, 100000, 200000};

  int checks = 0;
  int failures = 0;
  int carry_base = 0;
  int carry_seen = 0;
  int exit_cyc = 0;
  int prev_edit = 0;

  function automatic int cur_hms();
    return to_hms(4'(dif.hrs_d), dif.hrs_u, 4'(dif.min_d), dif.min_u, 4'(dif.sec_d), dif.sec_u);
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_tick(int at, int hms);
    tick_exp_t e;
    e.cyc = at;
    e.hms = hms;
    sb.push_back(e);
  endtask

  // One cycle: scoreboard the tick, visit the carry points, track the SET_MIN exit edge.
  task automatic step(int n);
    for (int k = 0; k < n; k++) begin
      tick_exp_t e;
      @(negedge clk);
      if (dif.tick_1hz) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", cyc, -1);
        end else begin
          e = sb.pop_front();
          check("tick_cycle", cyc, e.cyc);
          check("tick_time", cur_hms(), e.hms);
          $display("tick cyc=%0d time=%06d", cyc, cur_hms());
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        check("missed_tick", cyc, e.cyc);
      end
      if (rst_c_n && cyc == carry_base + 599) begin
        for (int i = 0; i < 3; i++) check("carry_before", int'(carry_hms[i]), exp599[i]);
        carry_seen += 3;
      end
      if (rst_c_n && cyc == carry_base + 600) begin
        for (int i = 0; i < 3; i++) check("carry_after", int'(carry_hms[i]), exp600[i]);
        carry_seen += 3;
      end
      if (prev_edit == 2 && int'(dif.edit_field) == 0) exit_cyc = cyc;
      prev_edit = int'(dif.edit_field);
    end
  endtask

  task automatic press(bit is_mode, int n);
    for (int p = 0; p < n; p++) begin
      if (is_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
      step(8);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got cycle %0d required completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int rst_edge;
    int found;

    vecs[0] = '{is_mode: 1'b0, presses: 6,  edit: 1, hms: 13803};
    vecs[1] = '{is_mode: 1'b1, presses: 1,  edit: 2, hms: 13803};
    vecs[2] = '{is_mode: 1'b0, presses: 25, edit: 2, hms: 10303};
    vecs[3] = '{is_mode: 1'b1, presses: 1,  edit: 0, hms: 10300};

    step(3);
    check("reset_time", cur_hms(), 193800);
    check("reset_edit", int'(dif.edit_field), 0);
    check("reset_blink", int'(dif.blink), 0);
    check("reset_tick", int'(dif.tick_1hz), 0);

    rst_edge   = cyc;
    carry_base = cyc;
    reset_n = 1'b1;
    rst_c_n = 1'b1;
    push_tick(rst_edge + 10, 193801);
    push_tick(rst_edge + 20, 193802);
    push_tick(rst_edge + 30, 193803);
    for (int i = 0; i < 31; i++) begin
      step(1);
      check("run_blink", int'(dif.blink), 0);
      check("run_edit", int'(dif.edit_field), 0);
    end
    check("run_ticks_left", sb.size(), 0);

    btn_mode = 1'b1;
    found = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (found == 0 && int'(dif.edit_field) == 1) found = i;
    end
    btn_mode = 1'b0;
    step(8);
    check("mode_within_8", int'(found >= 1 && found <= 8), 1);
    check("set_hrs_edit", int'(dif.edit_field), 1);
    check("frozen_start", cur_hms(), 193803);
    step(30);
    check("frozen_end", cur_hms(), 193803);

    for (int v = 0; v < 4; v++) begin
      press(vecs[v].is_mode, vecs[v].presses);
      $display("vec %0d mode=%0d n=%0d edit=%0d time=%06d", v, vecs[v].is_mode,
               vecs[v].presses, dif.edit_field, cur_hms());
      check("vec_edit", int'(dif.edit_field), vecs[v].edit);
      check("vec_time", cur_hms(), vecs[v].hms);
    end
    check("exit_age", cyc - exit_cyc, 9);
    push_tick(exit_cyc + 10, 10301);
    push_tick(exit_cyc + 20, 10302);
    push_tick(exit_cyc + 30, 10303);
    push_tick(exit_cyc + 40, 10304);
    step(25);
    press(1'b1, 1);
    check("reenter_edit", int'(dif.edit_field), 1);
    check("reenter_ticks_left", sb.size(), 0);
    check("reenter_time", cur_hms(), 10304);

    for (int i = 0; i < 10; i++) begin
      btn_inc = ~btn_inc;
      step(2);
    end
    btn_inc = 1'b1;
    step(10);
    btn_inc = 1'b0;
    step(8);
    check("bounce_one_inc", cur_hms(), 20304);
    $display("bounce time=%06d", cur_hms());

    btn_inc = 1'b1;
    step(3);
    btn_inc = 1'b0;
    step(10);
    check("glitch_no_inc", cur_hms(), 20304);

    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    step(8);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(8);
    check("both_edit", int'(dif.edit_field), 2);
    check("both_time", cur_hms(), 20304);

    for (int i = 0; i < 20; i++) begin
      step(1);
      check("set_blink", int'(dif.blink), int'(((cyc - exit_cyc) % CLK_HZ) >= CLK_HZ / 2));
    end

    btn_inc = 1'b1;
    step(8);
    check("pre_reset_inc", cur_hms(), 20404);
    check("pre_reset_queue", sb.size(), 0);
    reset_n = 1'b0;
    step(1);
    rst_edge = cyc;
    reset_n = 1'b1;
    check("midedit_reset_time", cur_hms(), 193800);
    check("midedit_reset_edit", int'(dif.edit_field), 0);
    check("midedit_reset_blink", int'(dif.blink), 0);
    push_tick(rst_edge + 10, 193801);
    push_tick(rst_edge + 20, 193802);
    push_tick(rst_edge + 30, 193803);
    step(21);
    btn_inc = 1'b0;
    step(10);
    check("held_inc_ignored", cur_hms(), 193803);
    check("held_inc_edit", int'(dif.edit_field), 0);
    press(1'b1, 1);
    check("post_reset_set", cur_hms(), 193803);
    press(1'b0, 1);
    check("post_reset_inc", cur_hms(), 203803);
    $display("final time=%06d edit=%0d", cur_hms(), dif.edit_field);

    check("final_queue", sb.size(), 0);
    check("carry_points_visited", carry_seen, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_controller.md
Name: time_set_controller

Overview:
- Owns the HH:MM:SS time-of-day state for the VGA clock display.
- Contains a 1 Hz prescaler and a full BCD carry chain.
- Provides a two-button set-mode FSM that lets a user adjust hours, then minutes.
- Drives the digit-field inputs of the display datapath plus a blink qualifier for the field being edited; runs on the pixel clock.

Parameters:
- CLK_HZ, 31_500_000, clock cycles per second; prescaler terminal count is CLK_HZ-1.
- DEBOUNCE_CYCLES, 315_000, consecutive stable cycles required to accept a button level change (10 ms).
- RST_HRS, 8'h19, BCD hours loaded at reset.
- RST_MIN, 8'h38, BCD minutes loaded at reset.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- btn_mode  in  1  raw asynchronous mode button, active high.
- btn_inc  in  1  raw asynchronous increment button, active high.
- sec_u  out  4  seconds units, BCD 0-9.
- sec_d  out  3  seconds tens, 0-5.
- min_u  out  4  minutes units, 0-9.
- min_d  out  3  minutes tens, 0-5.
- hrs_u  out  4  hours units, 0-9.
- hrs_d  out  2  hours tens, 0-2.
- edit_field  out  2  0=none, 1=hours, 2=minutes.
- blink  out  1  high = display should blank the field named by edit_field.
- tick_1hz  out  1  one-cycle pulse, high in the first cycle a new running time is visible.

Behaviour:
- Reset (reset_n low at a clk edge, any state, including mid-edit or mid-debounce):
  - Time loads RST_HRS:RST_MIN:00.
  - Prescaler cleared; FSM goes to RUN; debouncers return to released.
  - edit_field=0, blink=0, tick_1hz=0.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debounced level toggles only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A press event is a one-cycle pulse on the debounced rising edge.
  - Raw edge to press pulse: at most DEBOUNCE_CYCLES+4 cycles. Releases generate no event.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps to 0.
  - Runs in every FSM state.
  - "wrap" is the edge at which the count is CLK_HZ-1.
- FSM states: RUN, SET_HRS, SET_MIN.
  - RUN: on a wrap edge, advance time by one second; tick_1hz is high the following cycle. mode press goes to SET_HRS.
  - SET_HRS: time frozen (wrap does not advance). inc press increments hours 00..23, wrapping 23->00. mode press goes to SET_MIN.
  - SET_MIN: time frozen. inc press increments minutes 00..59, wrapping 59->00, with no carry into hours. mode press returns to RUN, and on that same edge zeroes seconds and clears the prescaler.
- Carry chain, all in one edge:
  - sec_u 9->0 carries into sec_d.
  - sec_d 5->0 carries into min_u, and likewise up through the hours.
  - 23:59:59 -> 00:00:00; 19:59:59 -> 20:00:00.
  - Fields never hold out-of-range values; no intermediate value (e.g. sec_u=10) is ever visible.
- Simultaneous events:
  - mode and inc pressed in the same cycle: mode is taken, inc is discarded.
  - inc press coinciding with a wrap in a SET state: the increment is applied and time does not otherwise advance.
- edit_field:
  - Registered; equals 1 in SET_HRS, 2 in SET_MIN, 0 in RUN.
  - Changes on the edge of the state change.
- blink: high in SET states while prescaler >= CLK_HZ/2; always 0 in RUN.
- tick_1hz: never asserted in SET states.
- All outputs are registered. No combinational path from btn_* to any output.

Decomposition:
- Shared package time_pkg, containing:
  - field width constants (SEC_U_W=4, SEC_D_W=3, MIN_U_W=4, MIN_D_W=3, HRS_U_W=4, HRS_D_W=2);
  - the edit_field encoding (EDIT_NONE, EDIT_HRS, EDIT_MIN);
  - the FSM state enum (RUN, SET_HRS, SET_MIN);
  - the limits MAX_HRS_D=2, MAX_HRS_U_AT_2=3, MAX_TENS_MIN_SEC=5.
- One sub-module, button_debounce:
  - Parameters: DEBOUNCE_CYCLES.
  - Ports: clk, reset_n, btn_raw, pressed.
  - Instantiated twice; contains the synchronizer, stability counter and edge pulse.

Test Plan:
1. Bench parameters CLK_HZ=10, DEBOUNCE_CYCLES=4.
   - Release reset -> time 19:38:00, edit_field=0, blink=0.
   - After 10 cycles, tick_1hz pulses once and time reads 19:38:01.
   - Pulses repeat every 10 cycles.
2. Carry chain:
   - Reset with RST_HRS=8'h23, RST_MIN=8'h59 and run 59 ticks -> 23:59:59.
   - Next tick -> 00:00:00 in a single step.
   - Also check 09:59:59 -> 10:00:00.
3. Set sequence:
   - Clean mode press -> edit_field=1 within 8 cycles; time frozen across 30 cycles.
   - 6 inc presses from 19 -> hours 01.
   - mode -> edit_field=2.
   - 25 inc presses from 38 -> minutes 03; hours unchanged.
   - mode -> RUN with seconds=00.
   - First tick_1hz exactly 10 cycles after the exit edge.
4. Bounce:
   - btn_inc toggling every 2 cycles for 20 cycles, then held high -> exactly one increment.
   - A 3-cycle glitch -> no increment.
5. Simultaneous presses and blink:
   - btn_mode and btn_inc rising together in SET_HRS -> state SET_MIN, hours unchanged.
   - blink high for prescaler 5..9 and low for 0..4 while in a SET state.
6. Reset mid-edit:
   - Assert reset_n low for 1 cycle in SET_MIN with btn_inc held high.
   - -> RUN, time 19:38:00, no increment after release until btn_inc is released and pressed again.
